// File: rtl/blackice_mx_clock_reset_ctrl_if.sv
// Board-side clock/reset signals of the BlackIce MX sequencer.
// The master modport is the sequencer; the slave modport is the board/PLL side.
interface blackice_mx_clock_reset_ctrl_if #(
  parameter int NUM_RESETS = 3,
  parameter int COUNT_W    = 4
);
  logic                  pll_locked;
  logic                  sw_reset_req;
  logic                  pll_resetb;
  logic [NUM_RESETS-1:0] rst_n;
  logic                  all_released;
  logic [COUNT_W-1:0]    lock_loss_count;

  modport master (
    input  pll_locked, sw_reset_req,
    output pll_resetb, rst_n, all_released, lock_loss_count
  );

  modport slave (
    output pll_locked, sw_reset_req,
    input  pll_resetb, rst_n, all_released, lock_loss_count
  );
endinterface

// File: rtl/blackice_mx_clock_reset_ctrl.sv
// PLL reset / lock-filter / staggered domain-reset sequencer, clocked from the board reference clock.
// Define CLOCK_RESET_WATCHDOG_EN to re-pulse the PLL reset when lock never arrives within LOCK_TIMEOUT cycles.
module blackice_mx_clock_reset_ctrl #(
  parameter int NUM_RESETS       = 3,
  parameter int PLL_RESET_CYCLES = 4,
  parameter int LOCK_FILTER      = 8,
  parameter int STAGE_DELAY      = 16,
  parameter int LOCK_TIMEOUT     = 1024,
  parameter int COUNT_W          = 4
) (
  input  logic                           clock_in,
  input  logic                           resetn,
  blackice_mx_clock_reset_ctrl_if.master bus
);

  localparam int PRC_W  = $clog2(PLL_RESET_CYCLES + 1);
  localparam int FILT_W = $clog2(LOCK_FILTER + 1);
  localparam int STG_W  = $clog2(STAGE_DELAY + 1);

  localparam logic [PRC_W-1:0]  PRC_LAST  = PRC_W'(PLL_RESET_CYCLES - 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
  localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(STAGE_DELAY - 1);
  localparam logic [NUM_RESETS-1:0] RST_ONE = NUM_RESETS'(1);

  if (NUM_RESETS < 1 || NUM_RESETS > 8 || PLL_RESET_CYCLES < 1 || LOCK_FILTER < 1 ||
      STAGE_DELAY < 1 || LOCK_TIMEOUT < 1 || COUNT_W < 1) begin : g_bad_params
    $error("blackice_mx_clock_reset_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {PLL_RST, WAIT_LOCK, RELEASE, RUN} state_t;

  state_t                state_q, state_d;
  logic                  sync1_q, lk_q;
  logic [PRC_W-1:0]      prc_q, prc_d;
  logic [FILT_W-1:0]     filt_q, filt_d;
  logic [STG_W-1:0]      stage_q, stage_d;
  logic [NUM_RESETS-1:0] rst_n_q, rst_n_d;
  logic                  pll_resetb_q, pll_resetb_d;
  logic                  all_rel_q, all_rel_d;
  logic [COUNT_W-1:0]    count_q, count_d;
  logic [NUM_RESETS-1:0] rel_mask;

  // Shifting a one in from the bottom guarantees ascending release order.
  assign rel_mask = (rst_n_q << 1) | RST_ONE;

`ifdef CLOCK_RESET_WATCHDOG_EN
  localparam int WD_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(LOCK_TIMEOUT - 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  always_comb begin
    state_d      = state_q;
    prc_d        = '0;
    filt_d       = '0;
    stage_d      = '0;
    rst_n_d      = rst_n_q;
    pll_resetb_d = 1'b1;
    all_rel_d    = &rst_n_q;
    count_d      = count_q;
`ifdef CLOCK_RESET_WATCHDOG_EN
    wd_d         = '0;
`endif
    unique case (state_q)
      PLL_RST: begin
        rst_n_d      = '0;
        pll_resetb_d = 1'b0;
        prc_d        = prc_q + 1'b1;
        if (prc_q == PRC_LAST) begin
          state_d      = WAIT_LOCK;
          prc_d        = '0;
          pll_resetb_d = 1'b1;
        end
      end
      WAIT_LOCK: begin
        rst_n_d = '0;
        filt_d  = lk_q ? filt_q + 1'b1 : '0;
`ifdef CLOCK_RESET_WATCHDOG_EN
        wd_d    = wd_q + 1'b1;
`endif
        if (lk_q && filt_q == FILT_LAST) begin
          state_d = RELEASE;
        end
`ifdef CLOCK_RESET_WATCHDOG_EN
        else if (wd_q == WD_LAST) begin
          state_d      = PLL_RST;
          pll_resetb_d = 1'b0;
        end
`endif
      end
      RELEASE, RUN: begin
        // Lock loss outranks a software request.
        if (!lk_q) begin
          state_d   = WAIT_LOCK;
          rst_n_d   = '0;
          all_rel_d = 1'b0;
          if (count_q != '1) count_d = count_q + 1'b1;
        end else if (bus.sw_reset_req) begin
          state_d   = RELEASE;
          rst_n_d   = '0;
          all_rel_d = 1'b0;
        end else if (state_q == RELEASE) begin
          stage_d = stage_q + 1'b1;
          if (stage_q == STG_LAST) begin
            stage_d = '0;
            rst_n_d = rel_mask;
            if (&rel_mask) state_d = RUN;
          end
        end
      end
      default: state_d = PLL_RST;
    endcase
  end

  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      state_q      <= PLL_RST;
      sync1_q      <= 1'b0;
      lk_q         <= 1'b0;
      prc_q        <= '0;
      filt_q       <= '0;
      stage_q      <= '0;
      rst_n_q      <= '0;
      pll_resetb_q <= 1'b0;
      all_rel_q    <= 1'b0;
      count_q      <= '0;
`ifdef CLOCK_RESET_WATCHDOG_EN
      wd_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      sync1_q      <= bus.pll_locked;
      lk_q         <= sync1_q;
      prc_q        <= prc_d;
      filt_q       <= filt_d;
      stage_q      <= stage_d;
      rst_n_q      <= rst_n_d;
      pll_resetb_q <= pll_resetb_d;
      all_rel_q    <= all_rel_d;
      count_q      <= count_d;
`ifdef CLOCK_RESET_WATCHDOG_EN
      wd_q         <= wd_d;
`endif
    end
  end

  assign bus.pll_resetb      = pll_resetb_q;
  assign bus.rst_n           = rst_n_q;
  assign bus.all_released    = all_rel_q;
  assign bus.lock_loss_count = count_q;

endmodule
